// File: rtl/tmr_scrub_reg.sv
// Triplicated, self-scrubbing register. The three copies (A/B/C) feed
// downstream majority voters and are reloaded from their own bitwise
// majority every cycle, so a single-copy upset persists for one cycle only.
// Upsets are counted per copy and reported through a one-entry valid/ready
// event buffer. An injection port flips bits in one chosen copy for testing.
module tmr_scrub_reg #(
    parameter int               WIDTH     = 8,
    parameter int               CNT_W     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             inj_en,
    input  logic [1:0]       inj_copy,
    input  logic [WIDTH-1:0] inj_mask,
    output logic [WIDTH-1:0] outA,
    output logic [WIDTH-1:0] outB,
    output logic [WIDTH-1:0] outC,
    output logic [WIDTH-1:0] voted,
    output logic             seu_valid,
    input  logic             seu_ready,
    output logic [2:0]       seu_copies,
    output logic [WIDTH-1:0] seu_diff,
    output logic             seu_overflow,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] cnt_A,
    output logic [CNT_W-1:0] cnt_B,
    output logic [CNT_W-1:0] cnt_C
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Index 0/1/2 = copy A/B/C throughout.
    logic [WIDTH-1:0] copy_q [3];
    logic [WIDTH-1:0] copy_d [3];
    logic [CNT_W-1:0] cnt_q  [3];
    logic [CNT_W-1:0] cnt_d  [3];

    logic             valid_q,    valid_d;
    logic [2:0]       copies_q,   copies_d;
    logic [WIDTH-1:0] evdiff_q,   evdiff_d;
    logic             overflow_q, overflow_d;

    logic [WIDTH-1:0] voted_w;
    logic [WIDTH-1:0] diff [3];
    logic [WIDTH-1:0] diff_any;
    logic [2:0]       up;
    logic [WIDTH-1:0] base;
    logic             pop;

    // Majority vote and per-copy disagreement with it.
    always_comb begin
        voted_w = (copy_q[0] & copy_q[1]) | (copy_q[0] & copy_q[2]) | (copy_q[1] & copy_q[2]);
        for (int k = 0; k < 3; k++) begin
            diff[k] = copy_q[k] ^ voted_w;
            up[k]   = |diff[k];
        end
        diff_any = diff[0] | diff[1] | diff[2];
    end

    // Next copy values: write or scrub, then optional bit flips in one copy.
    always_comb begin
        base = wr_en ? wr_data : voted_w;
        for (int k = 0; k < 3; k++) begin
            copy_d[k] = base ^ ((inj_en && inj_copy == 2'(k + 1)) ? inj_mask : '0);
        end
    end

    // Per-copy saturating upset counters; clear dominates increment.
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            if (clr_cnt) begin
                cnt_d[k] = '0;
            end else if (up[k] && cnt_q[k] != CNT_MAX) begin
                cnt_d[k] = cnt_q[k] + CNT_W'(1);
            end else begin
                cnt_d[k] = cnt_q[k];
            end
        end
    end

    // One-entry event buffer: a new upset fills it when empty or when the
    // current entry is being popped this cycle; otherwise it is dropped and
    // the sticky overflow flag records the loss.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned; that is what keeps this block free of latches.
        valid_d    = valid_q;
        copies_d   = copies_q;
        evdiff_d   = evdiff_q;
        overflow_d = overflow_q;
        pop        = valid_q && seu_ready;
        if (|up) begin
            if (!valid_q || pop) begin
                valid_d  = 1'b1;
                copies_d = up;
                evdiff_d = diff_any;
            end else begin
                overflow_d = 1'b1;
            end
        end else if (pop) begin
            valid_d = 1'b0;
        end
        if (clr_cnt) begin
            overflow_d = 1'b0;
        end
    end

    // State registers; reset drops any pending event.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < 3; k++) begin
                copy_q[k] <= RESET_VAL;
                cnt_q[k]  <= '0;
            end
            valid_q    <= 1'b0;
            copies_q   <= '0;
            evdiff_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            for (int k = 0; k < 3; k++) begin
                copy_q[k] <= copy_d[k];
                cnt_q[k]  <= cnt_d[k];
            end
            valid_q    <= valid_d;
            copies_q   <= copies_d;
            evdiff_q   <= evdiff_d;
            overflow_q <= overflow_d;
        end
    end

    assign outA         = copy_q[0];
    assign outB         = copy_q[1];
    assign outC         = copy_q[2];
    assign voted        = voted_w;
    assign seu_valid    = valid_q;
    assign seu_copies   = copies_q;
    assign seu_diff     = evdiff_q;
    assign seu_overflow = overflow_q;
    assign cnt_A        = cnt_q[0];
    assign cnt_B        = cnt_q[1];
    assign cnt_C        = cnt_q[2];

endmodule
